rom_fetch_buffer: RTL and testbench

//  Sits between the cartridge-mapper mux (ROM_ADDR/ROM_CE_N/ROM_OE_N/ROM_WORD) and the SDRAM port.

---
 rtl/rom_fetch_buffer.sv | 190 +++++++++++++++++++
 tb/tb_rom_fetch_buffer.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_fetch_buffer.sv
// rom_fetch_buffer: converts level-style mapper ROM read strobes into a
// req/ack fetch from SDRAM and keeps the last fetched 16-bit word so that
// repeated reads of the same word complete without a memory cycle.
// Optional feature: define ROM_FETCH_PREFETCH_EN to add a second entry (B)
// that is filled by a sequential prefetch after every demand fill.
module rom_fetch_buffer #(
    parameter int unsigned ADDR_W   = 24,
    parameter logic [15:0] RST_DATA = 16'hFFFF
) (
    input  logic              MCLK,
    input  logic              RESET,
    input  logic [ADDR_W-1:0] ROM_ADDR,
    input  logic [ADDR_W-1:0] ROM_MASK,
    input  logic              ROM_CE_N,
    input  logic              ROM_OE_N,
    input  logic              ROM_WORD,
    output logic [15:0]       ROM_Q,
    output logic              MEM_REQ,
    output logic [ADDR_W-2:0] MEM_ADDR,
    input  logic              MEM_ACK,
    input  logic [15:0]       MEM_DOUT,
    output logic              BUSY
);

    localparam int unsigned TAG_W = ADDR_W - 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic               req_q, req_d;
    logic [TAG_W-1:0]   addr_q, addr_d;

    // Demand entry
    logic               valid_a_q, valid_a_d;
    logic [TAG_W-1:0]   tag_a_q, tag_a_d;
    logic [15:0]        data_a_q, data_a_d;

`ifdef ROM_FETCH_PREFETCH_EN
    // Prefetch entry and prefetch bookkeeping
    logic               valid_b_q, valid_b_d;
    logic [TAG_W-1:0]   tag_b_q, tag_b_d;
    logic [15:0]        data_b_q, data_b_d;
    logic               pf_pend_q, pf_pend_d;
    logic               pf_act_q, pf_act_d;
    logic               hit_b;
    logic [TAG_W-1:0]   pf_tag;
`endif

    logic               rd;
    logic [TAG_W-1:0]   tag;
    logic               hit_a;
    logic               hit;
    logic               miss;
    logic               any_valid;
    logic [15:0]        sel_data;

    // Tag compare, hit detection and the combinational read-data mux
    always_comb begin
        rd    = ~ROM_CE_N & ~ROM_OE_N;
        tag   = TAG_W'((ROM_ADDR & ROM_MASK) >> 1);
        hit_a = valid_a_q && (tag_a_q == tag);
`ifdef ROM_FETCH_PREFETCH_EN
        hit_b     = valid_b_q && (tag_b_q == tag);
        hit       = hit_a | hit_b;
        any_valid = valid_a_q | valid_b_q;
        sel_data  = (hit_b && !hit_a) ? data_b_q : data_a_q;
        // Next sequential word, wrapped through the ROM size mask
        pf_tag    = TAG_W'(({tag_a_q + TAG_W'(1), 1'b0} & ROM_MASK) >> 1);
`else
        hit       = hit_a;
        any_valid = valid_a_q;
        sel_data  = data_a_q;
`endif
        miss = rd & ~hit;
        BUSY = miss;

        if (!any_valid) begin
            ROM_Q = RST_DATA;
        end else if (ROM_WORD) begin
            ROM_Q = sel_data;
        end else if (ROM_ADDR[0]) begin
            ROM_Q = {sel_data[15:8], sel_data[15:8]};
        end else begin
            ROM_Q = {sel_data[7:0], sel_data[7:0]};
        end

        MEM_REQ  = req_q;
        MEM_ADDR = addr_q;
    end

    // Fetch FSM next-state: issue on a demand miss (or pending prefetch), fill on ACK
    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        addr_d    = addr_q;
        valid_a_d = valid_a_q;
        tag_a_d   = tag_a_q;
        data_a_d  = data_a_q;
`ifdef ROM_FETCH_PREFETCH_EN
        valid_b_d = valid_b_q;
        tag_b_d   = tag_b_q;
        data_b_d  = data_b_q;
        pf_pend_d = pf_pend_q;
        pf_act_d  = pf_act_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (miss) begin
                    addr_d  = tag;
                    req_d   = 1'b1;
                    state_d = S_WAIT;
`ifdef ROM_FETCH_PREFETCH_EN
                    pf_act_d = 1'b0;
                end else if (pf_pend_q) begin
                    // Demand misses win; the prefetch only goes out on an idle cycle
                    addr_d    = pf_tag;
                    req_d     = 1'b1;
                    state_d   = S_WAIT;
                    pf_act_d  = 1'b1;
                    pf_pend_d = 1'b0;
`endif
                end
            end
            S_WAIT: begin
                if (MEM_ACK) begin
                    req_d   = 1'b0;
                    state_d = S_IDLE;
`ifdef ROM_FETCH_PREFETCH_EN
                    if (pf_act_q) begin
                        valid_b_d = 1'b1;
                        tag_b_d   = addr_q;
                        data_b_d  = MEM_DOUT;
                        pf_act_d  = 1'b0;
                    end else begin
                        valid_a_d = 1'b1;
                        tag_a_d   = addr_q;
                        data_a_d  = MEM_DOUT;
                        pf_pend_d = 1'b1;
                    end
`else
                    valid_a_d = 1'b1;
                    tag_a_d   = addr_q;
                    data_a_d  = MEM_DOUT;
`endif
                end
            end
            default: begin
                state_d = S_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // State and buffer registers with synchronous reset
    always_ff @(posedge MCLK) begin
        if (RESET) begin
            state_q   <= S_IDLE;
            req_q     <= 1'b0;
            addr_q    <= '0;
            valid_a_q <= 1'b0;
            tag_a_q   <= '0;
            data_a_q  <= RST_DATA;
`ifdef ROM_FETCH_PREFETCH_EN
            valid_b_q <= 1'b0;
            tag_b_q   <= '0;
            data_b_q  <= RST_DATA;
            pf_pend_q <= 1'b0;
            pf_act_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            addr_q    <= addr_d;
            valid_a_q <= valid_a_d;
            tag_a_q   <= tag_a_d;
            data_a_q  <= data_a_d;
`ifdef ROM_FETCH_PREFETCH_EN
            valid_b_q <= valid_b_d;
            tag_b_q   <= tag_b_d;
            data_b_q  <= data_b_d;
            pf_pend_q <= pf_pend_d;
            pf_act_q  <= pf_act_d;
`endif
        end
    end

endmodule

// File: tb/tb_rom_fetch_buffer.sv
// Testbench for rom_fetch_buffer: directed corner sequences, a vector table
// of hit / strobe combinations, and a randomized phase checked against a
// behavioural model (memory contents as a function of word address, plus
// the address of the most recently filled word).
module tb_rom_fetch_buffer;

    logic        MCLK = 1'b0;
    logic        RESET;
    logic [23:0] ROM_ADDR;
    logic [23:0] ROM_MASK;
    logic        ROM_CE_N;
    logic        ROM_OE_N;
    logic        ROM_WORD;
    logic [15:0] ROM_Q;
    logic        MEM_REQ;
    logic [22:0] MEM_ADDR;
    logic        MEM_ACK;
    logic [15:0] MEM_DOUT;
    logic        BUSY;

    rom_fetch_buffer #(.ADDR_W(24), .RST_DATA(16'hFFFF)) dut (
        .MCLK(MCLK), .RESET(RESET),
        .ROM_ADDR(ROM_ADDR), .ROM_MASK(ROM_MASK),
        .ROM_CE_N(ROM_CE_N), .ROM_OE_N(ROM_OE_N), .ROM_WORD(ROM_WORD),
        .ROM_Q(ROM_Q),
        .MEM_REQ(MEM_REQ), .MEM_ADDR(MEM_ADDR),
        .MEM_ACK(MEM_ACK), .MEM_DOUT(MEM_DOUT),
        .BUSY(BUSY)
    );

    always #5 MCLK = ~MCLK;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, got, exp);
    endtask

    // Reference memory contents for the randomized phase
    function automatic logic [15:0] memfn(input logic [22:0] a);
        logic [31:0] x;
        x = {9'd0, a} * 32'h9E3779B1;
        return x[31:16] ^ 16'h5A5A;
    endfunction

    function automatic logic [15:0] fmt(input logic [15:0] w, input logic word, input logic a0);
        if (word) return w;
        if (a0) return {w[15:8], w[15:8]};
        return {w[7:0], w[7:0]};
    endfunction

    task automatic rd_on(input logic [23:0] a, input logic w);
        ROM_ADDR = a; ROM_WORD = w; ROM_CE_N = 1'b0; ROM_OE_N = 1'b0;
    endtask

    // Wait (bounded) for MEM_REQ, sampled on negedges
    task automatic wait_req(input string name);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge MCLK);
            if (MEM_REQ) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check({name, "_timeout"}, 32'(MEM_REQ), 32'd1);
    endtask

    // Called at a negedge with MEM_REQ high: one-cycle ACK pulse
    task automatic do_ack(input logic [15:0] d);
        MEM_ACK = 1'b1; MEM_DOUT = d;
        @(negedge MCLK);
        MEM_ACK = 1'b0; MEM_DOUT = 16'h0000;
        #1;
    endtask

`ifdef ROM_FETCH_PREFETCH_EN
    task automatic pf_serve(input string name, input logic [22:0] exp_addr, input logic [15:0] d);
        wait_req(name);
        check({name, "_addr"}, 32'(MEM_ADDR), 32'(exp_addr));
        do_ack(d);
    endtask
`endif

    typedef struct {
        logic [23:0] addr;
        logic [23:0] mask;
        logic        ce_n;
        logic        oe_n;
        logic        word;
        logic        q_care;
        logic [15:0] q;
        logic        busy;
    } vec_t;

    vec_t tbl[8];

    // Random-phase model state
    logic        m_valid;
    logic [22:0] m_tag;
    logic        exp_req;
    logic [22:0] exp_addr;
    logic        prev_req;
    logic [22:0] prev_addr;
    logic        ack_now;
    logic        rd_c;
    logic [22:0] tag_c;
    int unsigned ack_wait;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // Buffer holds word 8 = 16'hBEEF when the table runs
        tbl[0] = '{24'h000010, 24'hFFFFFF, 1'b0, 1'b0, 1'b1, 1'b1, 16'hBEEF, 1'b0};
        tbl[1] = '{24'h000011, 24'hFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1, 16'hBEBE, 1'b0};
        tbl[2] = '{24'h000010, 24'hFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1, 16'hEFEF, 1'b0};
        tbl[3] = '{24'h300010, 24'h0000FF, 1'b0, 1'b0, 1'b1, 1'b1, 16'hBEEF, 1'b0};
        tbl[4] = '{24'h300011, 24'h0000FF, 1'b0, 1'b0, 1'b0, 1'b1, 16'hBEBE, 1'b0};
        tbl[5] = '{24'h000020, 24'hFFFFFF, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0};
        tbl[6] = '{24'h000020, 24'hFFFFFF, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0};
        tbl[7] = '{24'h000020, 24'hFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0};

        RESET = 1'b1; ROM_ADDR = '0; ROM_MASK = '1; ROM_CE_N = 1'b1; ROM_OE_N = 1'b1;
        ROM_WORD = 1'b1; MEM_ACK = 1'b0; MEM_DOUT = '0;
        repeat (3) @(negedge MCLK);
        RESET = 1'b0;
        #1;
        check("reset_q", 32'(ROM_Q), 32'hFFFF);
        check("reset_req", 32'(MEM_REQ), 32'd0);
        check("reset_addr", 32'(MEM_ADDR), 32'd0);
        check("reset_busy", 32'(BUSY), 32'd0);

        // Cold read: request one clock after the miss, data usable after ACK
        @(negedge MCLK);
        rd_on(24'h000010, 1'b1);
        #1;
        check("cold_busy", 32'(BUSY), 32'd1);
        check("cold_req_early", 32'(MEM_REQ), 32'd0);
        @(posedge MCLK); #1;
        check("cold_req", 32'(MEM_REQ), 32'd1);
        check("cold_addr", 32'(MEM_ADDR), 32'h000008);
        @(negedge MCLK);
        do_ack(16'hBEEF);
        check("cold_q", 32'(ROM_Q), 32'hBEEF);
        check("cold_busy_after", 32'(BUSY), 32'd0);
        check("cold_req_after", 32'(MEM_REQ), 32'd0);
`ifdef ROM_FETCH_PREFETCH_EN
        pf_serve("pf_cold", 23'h000009, 16'h1234);
        ROM_ADDR = 24'h000012; #1;
        check("pf_cold_hit_busy", 32'(BUSY), 32'd0);
        check("pf_cold_hit_q", 32'(ROM_Q), 32'h1234);
`endif

        // Byte hit on the buffered word
        ROM_ADDR = 24'h000011; ROM_WORD = 1'b0;
        #1;
        check("byte_q", 32'(ROM_Q), 32'hBEBE);
        check("byte_busy", 32'(BUSY), 32'd0);
        @(posedge MCLK); #1;
        check("byte_no_req", 32'(MEM_REQ), 32'd0);

        // Hit / strobe vector table
        for (int i = 0; i < 8; i++) begin
            @(negedge MCLK);
            ROM_ADDR = tbl[i].addr; ROM_MASK = tbl[i].mask; ROM_CE_N = tbl[i].ce_n;
            ROM_OE_N = tbl[i].oe_n; ROM_WORD = tbl[i].word;
            #1;
            check($sformatf("tbl%0d_busy", i), 32'(BUSY), 32'(tbl[i].busy));
            if (tbl[i].q_care) check($sformatf("tbl%0d_q", i), 32'(ROM_Q), 32'(tbl[i].q));
            @(posedge MCLK); #1;
            check($sformatf("tbl%0d_no_req", i), 32'(MEM_REQ), 32'd0);
        end

        // Mask applied to the memory address
        @(negedge MCLK);
        ROM_MASK = 24'h0FFFFF;
        rd_on(24'h300002, 1'b1);
        wait_req("mask_req");
        check("mask_addr", 32'(MEM_ADDR), 32'h000001);
        do_ack(16'hA55A);
        check("mask_q", 32'(ROM_Q), 32'hA55A);
`ifdef ROM_FETCH_PREFETCH_EN
        pf_serve("pf_mask", 23'h000002, 16'h2222);
`endif

        // Address change during WAIT: old fetch completes, new one follows
        @(negedge MCLK);
        ROM_MASK = '1;
        rd_on(24'h000040, 1'b1);
        wait_req("chg_req");
        check("chg_addr", 32'(MEM_ADDR), 32'h000020);
        ROM_ADDR = 24'h000060;
        @(negedge MCLK);
        check("chg_req_hold", 32'(MEM_REQ), 32'd1);
        check("chg_addr_hold", 32'(MEM_ADDR), 32'h000020);
        do_ack(16'h0404);
        ROM_ADDR = 24'h000040; #1;
        check("chg_old_busy", 32'(BUSY), 32'd0);
        check("chg_old_q", 32'(ROM_Q), 32'h0404);
        ROM_ADDR = 24'h000060; #1;
        check("chg_new_busy", 32'(BUSY), 32'd1);
        @(posedge MCLK); #1;
        check("chg_new_req", 32'(MEM_REQ), 32'd1);
        check("chg_new_addr", 32'(MEM_ADDR), 32'h000030);
        @(negedge MCLK);
        do_ack(16'h0606);
        check("chg_new_q", 32'(ROM_Q), 32'h0606);
        check("chg_new_busy_after", 32'(BUSY), 32'd0);
`ifdef ROM_FETCH_PREFETCH_EN
        pf_serve("pf_chg", 23'h000031, 16'h3131);
`endif

        // Reset while waiting; the late ACK must not fill the buffer
        @(negedge MCLK);
        rd_on(24'h000080, 1'b1);
        wait_req("rst_req");
        check("rst_addr", 32'(MEM_ADDR), 32'h000040);
        RESET = 1'b1; ROM_CE_N = 1'b1;
        @(negedge MCLK);
        RESET = 1'b0;
        #1;
        check("rst_req_drop", 32'(MEM_REQ), 32'd0);
        check("rst_busy", 32'(BUSY), 32'd0);
        @(negedge MCLK);
        do_ack(16'hDEAD);
        check("rst_q", 32'(ROM_Q), 32'hFFFF);
        check("rst_req_after", 32'(MEM_REQ), 32'd0);
        @(posedge MCLK); #1;
        check("rst_q_later", 32'(ROM_Q), 32'hFFFF);

`ifdef ROM_FETCH_PREFETCH_EN
        // Prefetch wraps to word 0 at the mask boundary
        @(negedge MCLK);
        ROM_MASK = 24'h0FFFFF;
        rd_on(24'h0FFFFE, 1'b1);
        wait_req("wrap_req");
        check("wrap_addr", 32'(MEM_ADDR), 32'h07FFFF);
        do_ack(16'h7777);
        check("wrap_q", 32'(ROM_Q), 32'h7777);
        pf_serve("pf_wrap", 23'h000000, 16'h0A0B);
        ROM_ADDR = 24'h000000; ROM_WORD = 1'b0; #1;
        check("wrap_hit_busy", 32'(BUSY), 32'd0);
        check("wrap_hit_q", 32'(ROM_Q), 32'h0B0B);
        @(posedge MCLK); #1;
        check("wrap_no_req", 32'(MEM_REQ), 32'd0);
`endif

        // Randomized phase against the behavioural model
        @(negedge MCLK);
        RESET = 1'b1; ROM_CE_N = 1'b1; ROM_OE_N = 1'b1; ROM_MASK = '1; MEM_ACK = 1'b0;
        @(negedge MCLK);
        RESET = 1'b0;
        m_valid = 1'b0; m_tag = '0; exp_req = 1'b0; exp_addr = '0;
        prev_req = 1'b0; prev_addr = '0; ack_wait = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge MCLK);
            MEM_ACK = 1'b0;
            #1;
            rd_c  = !ROM_CE_N && !ROM_OE_N;
            tag_c = 23'((ROM_ADDR & ROM_MASK) >> 1);
`ifdef ROM_FETCH_PREFETCH_EN
            if (rd_c && m_valid && m_tag == tag_c) check("rnd_busy_hit", 32'(BUSY), 32'd0);
`else
            check("rnd_busy", 32'(BUSY), 32'(rd_c && !(m_valid && m_tag == tag_c)));
            check("rnd_req", 32'(MEM_REQ), 32'(exp_req));
            if (exp_req) check("rnd_addr", 32'(MEM_ADDR), 32'(exp_addr));
`endif
            if (prev_req && MEM_REQ) check("rnd_addr_hold", 32'(MEM_ADDR), 32'(prev_addr));
            if (rd_c && !BUSY)
                check("rnd_q", 32'(ROM_Q), 32'(fmt(memfn(tag_c), ROM_WORD, ROM_ADDR[0])));

            // Memory responder: random 0-3 cycle latency, stray ACKs while idle
            if (MEM_REQ && !prev_req) ack_wait = $urandom_range(0, 3);
            ack_now = 1'b0;
            if (MEM_REQ) begin
                if (ack_wait == 0) begin
                    ack_now  = 1'b1;
                    MEM_ACK  = 1'b1;
                    MEM_DOUT = memfn(MEM_ADDR);
                    m_valid  = 1'b1;
                    m_tag    = MEM_ADDR;
                end else begin
                    ack_wait--;
                end
            end else if ($urandom_range(0, 7) == 0) begin
                MEM_ACK  = 1'b1;
                MEM_DOUT = 16'($urandom);
            end
            prev_req  = MEM_REQ;
            prev_addr = MEM_ADDR;

            if ($urandom_range(0, 1) == 1) begin
                ROM_ADDR = {4'($urandom_range(0, 3)), 12'h000, 8'($urandom_range(0, 15))};
                ROM_WORD = 1'($urandom_range(0, 1));
                ROM_CE_N = ($urandom_range(0, 3) == 0);
                ROM_OE_N = ($urandom_range(0, 3) == 0);
            end
            if ($urandom_range(0, 31) == 0) begin
                case ($urandom_range(0, 2))
                    0:       ROM_MASK = 24'hFFFFFF;
                    1:       ROM_MASK = 24'h00FFFF;
                    default: ROM_MASK = 24'h0000FF;
                endcase
            end

            // Expected request state after the coming edge
            rd_c  = !ROM_CE_N && !ROM_OE_N;
            tag_c = 23'((ROM_ADDR & ROM_MASK) >> 1);
            if (MEM_REQ && !ack_now) begin
                exp_req = 1'b1; exp_addr = MEM_ADDR;
            end else if (!MEM_REQ && rd_c && !(m_valid && m_tag == tag_c)) begin
                exp_req = 1'b1; exp_addr = tag_c;
            end else begin
                exp_req = 1'b0;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
